// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: access codes,
// FSM state encoding and request classification helpers.
package dmem_pkg;

  localparam logic [3:0] ACC_LW  = 4'd1;
  localparam logic [3:0] ACC_LH  = 4'd2;
  localparam logic [3:0] ACC_LB  = 4'd3;
  localparam logic [3:0] ACC_LHU = 4'd4;
  localparam logic [3:0] ACC_LBU = 4'd5;
  localparam logic [3:0] ACC_SW  = 4'd6;
  localparam logic [3:0] ACC_SH  = 4'd7;
  localparam logic [3:0] ACC_SB  = 4'd8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } dmem_state_e;

  function automatic logic is_load(input logic [3:0] acc);
    return (acc >= ACC_LW) && (acc <= ACC_LBU);
  endfunction

  function automatic logic is_sub_store(input logic [3:0] acc);
    return (acc == ACC_SH) || (acc == ACC_SB);
  endfunction

  // Word accesses need both low bits clear, half accesses need bit 0 clear.
  function automatic logic is_misaligned(input logic [3:0] acc, input logic [1:0] lo);
    return (((acc == ACC_LW) || (acc == ACC_SW)) && (lo != 2'b00)) ||
           (((acc == ACC_LH) || (acc == ACC_LHU) || (acc == ACC_SH)) && lo[0]);
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: byte/half extraction with sign/zero extension for
// loads, and insertion of the store half/byte into the read word for sh/sb.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [3:0]  access_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*off_i +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (access_i)
      ACC_LH:  load_o = {{16{half_sel[15]}}, half_sel};
      ACC_LHU: load_o = {16'h0000, half_sel};
      ACC_LB:  load_o = {{24{byte_sel[7]}}, byte_sel};
      ACC_LBU: load_o = {24'h000000, byte_sel};
      default: load_o = rdata_i;
    endcase

    merge_o = rdata_i;
    if (access_i == ACC_SH) begin
      if (off_i[1]) merge_o[31:16] = wdata_i;
      else          merge_o[15:0]  = wdata_i;
    end else if (access_i == ACC_SB) begin
      merge_o[8*off_i +: 8] = wdata_i[7:0];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle load/store sequencer for a single-port synchronous-read memory.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and the requester holds the request until it
// transfers. resp_valid is a single-cycle pulse with no backpressure.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_access,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output dmem_state_e       dbg_state
);

  dmem_state_e       state_q, state_d;
  logic [3:0]        access_q, access_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wbuf_q, wbuf_d;      // store data, then merged word for sh/sb
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] lane_load, lane_merge;
  logic        req_mis;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_mis = is_misaligned(req_access, req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  dmem_lane u_lane (
    .access_i (access_q),
    .off_i    (addr_q[1:0]),
    .rdata_i  (mem_rdata),
    .wdata_i  (wbuf_q[15:0]),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      access_q <= 4'd0;
      addr_q   <= '0;
      wbuf_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      addr_q   <= addr_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    addr_d   = addr_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          access_d = req_access;
          addr_d   = req_addr[ADDR_W+1:0];
          wbuf_d   = req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_mis;
          if (req_mis)                                       state_d = RSP;
          else if (is_load(req_access) || is_sub_store(req_access)) state_d = RD;
          else if (req_access == ACC_SW)                     state_d = WR;
          else                                               state_d = RSP;
        end
      end
      RD:  state_d = MRG;
      MRG: begin
        if (is_load(access_q)) begin
          rdata_d = lane_load;
          state_d = RSP;
        end else begin
          wbuf_d  = lane_merge;
          state_d = WR;
        end
      end
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RSP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_we     = (state_q == WR);
  assign mem_wdata  = wbuf_q;
  assign dbg_state  = state_q;

endmodule
